// File: rtl/guess_sequencer.sv
// guess_sequencer: odometer-order keyspace walker that emits one guess
// per clock over a valid/ready handshake, growing length on wrap.
module guess_sequencer #(
  parameter int MAX_LEN = 16,
  parameter int IDX_W   = 8,
  parameter int CNT_W   = 48
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [IDX_W:0]           radix,
  input  logic [4:0]               min_len,
  input  logic [4:0]               max_len,
  input  logic [MAX_LEN*IDX_W-1:0] start_idx,
  input  logic [CNT_W-1:0]         count,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [MAX_LEN*IDX_W-1:0] guess_idx,
  output logic [4:0]               guess_len,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  typedef logic [MAX_LEN-1:0][IDX_W-1:0] vec_t;

  state_t           state, state_n;
  vec_t             dig, dig_n;
  vec_t             sdig, inc, masked;
  logic [4:0]       len, len_n;
  logic [4:0]       mlen, mlen_n;
  logic [IDX_W:0]   rad, rad_n, rad_m1;
  logic [CNT_W-1:0] lim, lim_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             err, err_n;
  logic [MAX_LEN-1:0] at_max, pre;
  logic             wrap_all, key_end, cnt_end;
  logic             hs, bad;

  assign sdig   = start_idx;
  assign rad_m1 = rad - 1'b1;

  // Digits at or above len count as saturated so one AND-reduce
  // of a masked vector yields each digit's carry-in in parallel.
  always_comb begin
    for (int i = 0; i < MAX_LEN; i++)
      at_max[i] = (i >= int'(len)) ||
                  ({1'b0, dig[i]} == rad_m1);
    for (int i = 0; i < MAX_LEN; i++)
      pre[i] = &(at_max |
                 ~((MAX_LEN'(1) << i) - MAX_LEN'(1)));
    for (int i = 0; i < MAX_LEN; i++) begin
      inc[i] = dig[i];
      if (i < int'(len) && pre[i])
        inc[i] = at_max[i] ? '0 : dig[i] + 1'b1;
    end
  end

  assign wrap_all = &at_max;
  assign key_end  = wrap_all && (len == mlen);
  assign cnt_end  = (lim != '0) && (cnt == lim - 1'b1);

  always_comb begin
    bad = (radix < (IDX_W+1)'(2)) ||
          (min_len == '0) ||
          (min_len > max_len) ||
          (int'(max_len) > MAX_LEN);
    for (int i = 0; i < MAX_LEN; i++) begin
      masked[i] = '0;
      if (i < int'(min_len)) begin
        masked[i] = sdig[i];
        if ({1'b0, sdig[i]} >= radix)
          bad = 1'b1;
      end
    end
  end

  assign out_valid = (state == S_RUN);
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign cfg_err   = err;
  assign guess_idx = dig;
  assign guess_len = len;
  assign out_last  = out_valid && (key_end || cnt_end);
  assign hs        = out_valid && out_ready;

  always_comb begin
    state_n = state;
    dig_n   = dig;
    len_n   = len;
    mlen_n  = mlen;
    rad_n   = rad;
    lim_n   = lim;
    cnt_n   = cnt;
    err_n   = err;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start && !abort) begin
          cnt_n  = '0;
          rad_n  = radix;
          mlen_n = max_len;
          lim_n  = count;
          if (bad) begin
            state_n = S_DONE;
            err_n   = 1'b1;
            dig_n   = '0;
            len_n   = '0;
          end else begin
            state_n = S_RUN;
            err_n   = 1'b0;
            dig_n   = masked;
            len_n   = min_len;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_n = S_DONE;
          err_n   = 1'b0;
        end else if (hs) begin
          cnt_n = cnt + 1'b1;
          if (out_last) begin
            state_n = S_DONE;
          end else if (wrap_all) begin
            len_n = len + 5'd1;
            dig_n = '0;
          end else begin
            dig_n = inc;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      dig   <= '0;
      len   <= '0;
      mlen  <= '0;
      rad   <= '0;
      lim   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      dig   <= dig_n;
      len   <= len_n;
      mlen  <= mlen_n;
      rad   <= rad_n;
      lim   <= lim_n;
      cnt   <= cnt_n;
      err   <= err_n;
    end
  end

endmodule
